instr_mem_sync: RTL and testbench

- Parametrised, synchronous-read instruction memory for the RV32I processor. Replaces the fixed, asynchronous, hard-assigned instruction store.
- Byte-addressed fetch port with a one-cycle registered read, a valid/stall handshake and alignment and range fault detection.
- Separate program-load write port, so instruction images are loaded at run time by a testbench or boot loader rather than hard-coded.
- Built-in clear sequencer fills the memory with NOPs after reset.
- Sits between the PC/fetch stage and the IF/ID pipeline register.

---
 rtl/instr_mem_sync_if.sv | 39 +++
 rtl/instr_mem_sync.sv | 115 +++++++++++
 tb/tb_instr_mem_sync.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_sync_if.sv
// rtl/instr_mem_sync_if.sv - fetch and program-load bus for instr_mem_sync
// Parity signals exist only when IMEM_PARITY_EN is defined.
interface instr_mem_sync_if #(
  parameter int ADDR_W = 32,
  parameter int INS_W  = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;
  logic [INS_W-1:0]  instr;
  logic              instr_valid;
  logic              fetch_fault;
  logic              mem_ready;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [INS_W-1:0]  prog_data;
`ifdef IMEM_PARITY_EN
  logic              parity_err;
  logic              prog_par_inv;
`endif

  modport master (
    output fetch_req, fetch_addr, stall, prog_we, prog_addr, prog_data,
`ifdef IMEM_PARITY_EN
    output prog_par_inv,
    input  parity_err,
`endif
    input  instr, instr_valid, fetch_fault, mem_ready
  );

  modport slave (
    input  fetch_req, fetch_addr, stall, prog_we, prog_addr, prog_data,
`ifdef IMEM_PARITY_EN
    input  prog_par_inv,
    output parity_err,
`endif
    output instr, instr_valid, fetch_fault, mem_ready
  );
endinterface

// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - synchronous-read instruction memory with NOP clear and program-load port
// Optional per-word even parity is enabled with IMEM_PARITY_EN.
module instr_mem_sync #(
  parameter int               ADDR_W   = 32,
  parameter int               INS_W    = 32,
  parameter int               DEPTH    = 64,
  parameter logic [INS_W-1:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_mem_sync_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MW = INS_W + 1;
`else
  localparam int MW = INS_W;
`endif
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 4);

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_t;

  state_t         state, state_nx;
  logic [AW-1:0]  cnt, cnt_nx;
  logic [MW-1:0]  mem [DEPTH];
  logic [MW-1:0]  rd_q;
  logic           valid_q, fault_q, nop_q;

  logic           we;
  logic [AW-1:0]  waddr;
  logic [MW-1:0]  wdata;
  logic [MW-1:0]  nop_entry, prog_entry;
  logic           prog_ok, fetch_bad, accept;
  logic [AW-1:0]  ridx, pidx;

  assign ridx      = bus.fetch_addr[AW+1:2];
  assign pidx      = bus.prog_addr[AW+1:2];
  assign fetch_bad = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr >= LIMIT);
  assign prog_ok   = (bus.prog_addr[1:0] == 2'b00) && (bus.prog_addr < LIMIT);
  assign accept    = bus.fetch_req && (state == S_READY) && !bus.stall;

`ifdef IMEM_PARITY_EN
  assign nop_entry  = {^NOP_WORD, NOP_WORD};
  assign prog_entry = {(^bus.prog_data) ^ bus.prog_par_inv, bus.prog_data};
`else
  assign nop_entry  = NOP_WORD;
  assign prog_entry = bus.prog_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The clear sequencer owns the single write port until READY.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    we       = 1'b0;
    waddr    = pidx;
    wdata    = prog_entry;
    if (state == S_INIT) begin
      we     = 1'b1;
      waddr  = cnt;
      wdata  = nop_entry;
      cnt_nx = cnt + 1'b1;
      if (cnt == AW'(DEPTH - 1))
        state_nx = S_READY;
    end else begin
      we = bus.prog_we && prog_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  // Raw RAM output register; read-first falls out of the shared edge.
  always_ff @(posedge clk) begin
    if (accept)
      rd_q <= mem[ridx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      nop_q   <= 1'b1;
    end else if (!bus.stall) begin
      valid_q <= accept;
      fault_q <= accept && fetch_bad;
      if (accept)
        nop_q <= fetch_bad;
    end
  end

  assign bus.instr_valid = valid_q;
  assign bus.fetch_fault = fault_q;
  assign bus.mem_ready   = (state == S_READY);

`ifdef IMEM_PARITY_EN
  logic par_bad;
  assign par_bad        = ^rd_q;
  assign bus.instr      = (nop_q || par_bad) ? NOP_WORD : rd_q[INS_W-1:0];
  assign bus.parity_err = valid_q && !nop_q && par_bad;
`else
  assign bus.instr      = nop_q ? NOP_WORD : rd_q;
`endif
endmodule

// File: tb/tb_instr_mem_sync.sv
// tb/tb_instr_mem_sync.sv - randomized self-checking bench for instr_mem_sync
// Reference model is a word array plus the fetch/stall rules in plain arithmetic.
module tb_instr_mem_sync;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] LIMIT = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_sync_if #(.ADDR_W(32), .INS_W(32)) bus();

  instr_mem_sync #(.ADDR_W(32), .INS_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model [DEPTH];
  bit          model_perr [DEPTH];
  logic [31:0] exp_instr;
  logic        exp_valid, exp_fault, exp_perr;

  task automatic idle();
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.stall      = 1'b0;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_data  = '0;
`ifdef IMEM_PARITY_EN
    bus.prog_par_inv = 1'b0;
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      model[i]      = NOP;
      model_perr[i] = 1'b0;
    end
  endtask

  function automatic bit addr_bad(logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= LIMIT);
  endfunction

  function automatic logic [31:0] exp_word(logic [31:0] a);
    int idx;
    if (addr_bad(a)) return NOP;
    idx = int'(a >> 2);
    if (model_perr[idx]) return NOP;
    return model[idx];
  endfunction

  task automatic model_write(logic [31:0] a, logic [31:0] d, bit inv);
    int idx;
    if (!addr_bad(a)) begin
      idx             = int'(a >> 2);
      model[idx]      = d;
`ifdef IMEM_PARITY_EN
      model_perr[idx] = inv;
`else
      model_perr[idx] = 1'b0;
      if (inv) model_perr[idx] = 1'b0;
`endif
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, DEPTH + 3)) << 2;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 31) == 0) a = $urandom;
    return a;
  endfunction

  task automatic do_prog(logic [31:0] a, logic [31:0] d, bit inv);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
`ifdef IMEM_PARITY_EN
    bus.prog_par_inv = inv;
`endif
    @(negedge clk);
    idle();
    model_write(a, d, inv);
  endtask

  task automatic drive_fetch(logic [31:0] a);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    bus.stall      = 1'b0;
    @(negedge clk);
    bus.fetch_req  = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (bus.mem_ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    bit saw_valid;
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_fault, bus.mem_ready, bus.instr} !== {3'b000, NOP}) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b f=%b r=%b i=%h expected 000 %h",
               bus.instr_valid, bus.fetch_fault, bus.mem_ready, bus.instr, NOP);
    end
    rst_n = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0;
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 32'h0;
    bus.prog_data  = 32'hFFFF_FFFF;
    cyc = 0;
    saw_valid = 1'b0;
    while (bus.mem_ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.instr_valid === 1'b1) saw_valid = 1'b1;
    end
    idle();
    model_clear();
    n_cmp++;
    if (cyc != DEPTH) begin
      n_bad++;
      $display("FAIL ready_latency: got %0d cycles expected %0d", cyc, DEPTH);
    end
    n_cmp++;
    if (saw_valid) begin
      n_bad++;
      $display("FAIL init_ignores_fetch: got instr_valid=1 during clear expected 0");
    end
    drive_fetch(32'h0);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_fault, bus.instr} !== {2'b10, NOP}) begin
      n_bad++;
      $display("FAIL first_fetch: got v=%b f=%b i=%h expected 10 %h",
               bus.instr_valid, bus.fetch_fault, bus.instr, NOP);
    end
  endtask

  task automatic test_load_fetch();
    do_prog(32'h0, 32'h0020_0093, 1'b0);
    do_prog(32'h4, 32'h0010_0113, 1'b0);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0;
    @(negedge clk);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_fault, bus.instr} !== {2'b10, 32'h0020_0093}) begin
      n_bad++;
      $display("FAIL b2b_first: got v=%b f=%b i=%h expected 10 00200093",
               bus.instr_valid, bus.fetch_fault, bus.instr);
    end
    bus.fetch_addr = 32'h4;
    @(negedge clk);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_fault, bus.instr} !== {2'b10, 32'h0010_0113}) begin
      n_bad++;
      $display("FAIL b2b_second: got v=%b f=%b i=%h expected 10 00100113",
               bus.instr_valid, bus.fetch_fault, bus.instr);
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_fault, bus.instr} !== {2'b00, 32'h0010_0113}) begin
      n_bad++;
      $display("FAIL idle_hold: got v=%b f=%b i=%h expected 00 00100113",
               bus.instr_valid, bus.fetch_fault, bus.instr);
    end
  endtask

  task automatic test_faults();
    logic [31:0] bad_addrs [2];
    bad_addrs[0] = 32'h6;
    bad_addrs[1] = 32'h100;
    foreach (bad_addrs[k]) begin
      drive_fetch(bad_addrs[k]);
      n_cmp++;
      if ({bus.instr_valid, bus.fetch_fault, bus.instr} !== {2'b11, NOP}) begin
        n_bad++;
        $display("FAIL fault_fetch_%h: got v=%b f=%b i=%h expected 11 %h",
                 bad_addrs[k], bus.instr_valid, bus.fetch_fault, bus.instr, NOP);
      end
    end
    do_prog(32'h102, $urandom, 1'b0);
    do_prog(32'h9, $urandom, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      drive_fetch(32'(i * 4));
      n_cmp++;
      if (bus.instr !== exp_word(32'(i * 4))) begin
        n_bad++;
        $display("FAIL dropped_write_word%0d: got %h expected %h", i, bus.instr, exp_word(32'(i * 4)));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] r;
    r = $urandom;
    do_prog(32'h8, r, 1'b0);
    drive_fetch(32'h4);
    n_cmp++;
    if (bus.instr !== 32'h0010_0113) begin
      n_bad++;
      $display("FAIL stall_pre: got %h expected 00100113", bus.instr);
    end
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h8;
    bus.stall      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.instr_valid, bus.fetch_fault, bus.instr} !== {2'b10, 32'h0010_0113}) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got v=%b f=%b i=%h expected 10 00100113",
                 c, bus.instr_valid, bus.fetch_fault, bus.instr);
      end
    end
    bus.stall = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_fault, bus.instr} !== {2'b10, r}) begin
      n_bad++;
      $display("FAIL stall_release: got v=%b f=%b i=%h expected 10 %h",
               bus.instr_valid, bus.fetch_fault, bus.instr, r);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    logic [31:0] old;
    old = exp_word(32'h10);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 32'h10;
    bus.prog_data  = 32'hDEAD_BEEF;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h10;
    @(negedge clk);
    idle();
    model_write(32'h10, 32'hDEAD_BEEF, 1'b0);
    n_cmp++;
    if (bus.instr !== old) begin
      n_bad++;
      $display("FAIL read_first_old: got %h expected %h", bus.instr, old);
    end
    drive_fetch(32'h10);
    n_cmp++;
    if (bus.instr !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL read_first_new: got %h expected deadbeef", bus.instr);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] fa, pa, pd;
    bit req, stl, pwe, inv;
    exp_instr = 32'hDEAD_BEEF;
    exp_valid = 1'b0;
    exp_fault = 1'b0;
    exp_perr  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 3) != 0);
      stl = ($urandom_range(0, 4) == 0);
      pwe = ($urandom_range(0, 2) == 0);
      inv = ($urandom_range(0, 7) == 0);
      fa  = rand_addr();
      pa  = rand_addr();
      pd  = $urandom;
      bus.fetch_req  = req;
      bus.fetch_addr = fa;
      bus.stall      = stl;
      bus.prog_we    = pwe;
      bus.prog_addr  = pa;
      bus.prog_data  = pd;
`ifdef IMEM_PARITY_EN
      bus.prog_par_inv = inv;
`else
      inv = 1'b0;
`endif
      if (!stl) begin
        exp_valid = req;
        exp_fault = req && addr_bad(fa);
        exp_perr  = req && !addr_bad(fa) && model_perr[int'(fa >> 2)];
        if (req) exp_instr = exp_word(fa);
      end
      if (pwe) model_write(pa, pd, inv);
      @(negedge clk);
      n_cmp++;
      if ({bus.instr_valid, bus.fetch_fault, bus.instr} !== {exp_valid, exp_fault, exp_instr}) begin
        n_bad++;
        $display("FAIL random_%0d: got v=%b f=%b i=%h expected %b%b %h",
                 i, bus.instr_valid, bus.fetch_fault, bus.instr, exp_valid, exp_fault, exp_instr);
      end
`ifdef IMEM_PARITY_EN
      n_cmp++;
      if (bus.parity_err !== exp_perr) begin
        n_bad++;
        $display("FAIL random_parity_%0d: got %b expected %b", i, bus.parity_err, exp_perr);
      end
`endif
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    drive_fetch(32'h0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_fault, bus.mem_ready, bus.instr} !== {3'b000, NOP}) begin
      n_bad++;
      $display("FAIL async_reset_ready: got v=%b f=%b r=%b i=%h expected 000 %h",
               bus.instr_valid, bus.fetch_fault, bus.mem_ready, bus.instr, NOP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (bus.mem_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_init_ready: got %b expected 0", bus.mem_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.instr_valid, bus.mem_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL async_reset_init: got v=%b r=%b expected 00", bus.instr_valid, bus.mem_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(cyc);
    model_clear();
    n_cmp++;
    if (cyc != DEPTH) begin
      n_bad++;
      $display("FAIL re_ready_latency: got %0d cycles expected %0d", cyc, DEPTH);
    end
    drive_fetch(32'h10);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_fault, bus.instr} !== {2'b10, NOP}) begin
      n_bad++;
      $display("FAIL cleared_after_reset: got v=%b f=%b i=%h expected 10 %h",
               bus.instr_valid, bus.fetch_fault, bus.instr, NOP);
    end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    do_prog(32'h14, 32'h1234_5678, 1'b1);
    drive_fetch(32'h14);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_fault, bus.parity_err, bus.instr} !== {3'b101, NOP}) begin
      n_bad++;
      $display("FAIL parity_inject: got v=%b f=%b p=%b i=%h expected 101 %h",
               bus.instr_valid, bus.fetch_fault, bus.parity_err, bus.instr, NOP);
    end
    do_prog(32'h14, 32'h1234_5678, 1'b0);
    drive_fetch(32'h14);
    n_cmp++;
    if ({bus.parity_err, bus.instr} !== {1'b0, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL parity_clean: got p=%b i=%h expected 0 12345678", bus.parity_err, bus.instr);
    end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_load_fetch();
    test_faults();
    test_stall();
    test_same_cycle();
    test_random();
    test_reset_mid();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
